// File: rtl/centroid_pkg.sv
// Shared types and width helpers for the centroid/bounding-box block.
package centroid_pkg;

   localparam int COORD_W_DEF = 11;

   function automatic int area_width(input int img_w, input int img_h);
      return $clog2(img_w * img_h + 1);
   endfunction

   // Sized so that a full frame of maximal coordinates cannot overflow.
   function automatic int sum_width(input int area_w, input int coord_w);
      return area_w + coord_w;
   endfunction

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DIV,
      ST_DONE
   } state_t;

endpackage

// File: rtl/centroid_bbox_divider.sv
// Restoring unsigned divider: one quotient bit per cycle, N_W cycles from start.
module seq_divider #(
   parameter int N_W = 24,
   parameter int D_W = 13
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [N_W-1:0] dividend,
   input  logic [D_W-1:0] divisor,
   output logic           done,
   output logic [N_W-1:0] quotient
);

   localparam int CNT_W = $clog2(N_W + 1);

   logic [D_W-1:0]   rem;
   logic [D_W-1:0]   dvs;
   logic [N_W-1:0]   quo;
   logic [CNT_W-1:0] cnt;
   logic             run;
   logic [D_W:0]     shifted;
   logic [D_W+1:0]   diff;

   always_comb begin
      shifted = {rem, quo[N_W-1]};
      diff    = {1'b0, shifted} - {2'b00, dvs};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem <= '0;
         dvs <= '0;
         quo <= '0;
         cnt <= '0;
         run <= 1'b0;
      end else if (start) begin
         rem <= '0;
         dvs <= divisor;
         quo <= dividend;
         cnt <= CNT_W'(N_W);
         run <= 1'b1;
      end else if (run) begin
         // Negative trial difference: restore (keep shifted value), quotient bit 0.
         if (diff[D_W+1]) begin
            rem <= shifted[D_W-1:0];
            quo <= {quo[N_W-2:0], 1'b0};
         end else begin
            rem <= diff[D_W-1:0];
            quo <= {quo[N_W-2:0], 1'b1};
         end
         cnt <= cnt - CNT_W'(1);
         if (cnt == CNT_W'(1)) run <= 1'b0;
      end
   end

   // Asserted during the final step; quotient is complete after this edge.
   assign done     = run && (cnt == CNT_W'(1));
   assign quotient = quo;

endmodule

// File: rtl/centroid_bbox.sv
// Per-frame mask centroid and area, with optional bounding box (CENTROID_BBOX_EN).
module centroid_bbox
   import centroid_pkg::*;
#(
   parameter int  IMG_W    = 64,
   parameter int  IMG_H    = 64,
   parameter int  COORD_W  = COORD_W_DEF,
   parameter int  MIN_AREA = 1,
   localparam int AREA_W   = area_width(IMG_W, IMG_H),
   localparam int SUM_W    = sum_width(AREA_W, COORD_W)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               ce,
   input  logic               de,
   input  logic               hsync,
   input  logic               vsync,
   input  logic               mask,
   output logic [COORD_W-1:0] x,
   output logic [COORD_W-1:0] y,
   output logic [COORD_W-1:0] x_min,
   output logic [COORD_W-1:0] x_max,
   output logic [COORD_W-1:0] y_min,
   output logic [COORD_W-1:0] y_max,
   output logic [AREA_W-1:0]  area,
   output logic               valid,
   output logic               found,
   output logic               busy,
   output logic               frame_drop
);

   state_t             state, state_nx;
   logic               vsync_q;
   logic [COORD_W-1:0] x_cnt, y_cnt;
   logic [AREA_W-1:0]  m00, sh_area;
   logic [SUM_W-1:0]   m10, m01, qx, qy;
   logic               sh_found, div_start, dx_done, dy_done;
   logic               adv, pix, eof, go, snap;
   logic               unused_sig;

   assign adv  = ce & de;
   assign pix  = ce & de & mask;
   assign eof  = vsync & ~vsync_q;
   assign go   = (m00 >= AREA_W'(MIN_AREA));
   assign snap = eof && (state == ST_IDLE);
   assign busy = (state != ST_IDLE);
   assign unused_sig = ^{hsync, qx[SUM_W-1:COORD_W], qy[SUM_W-1:COORD_W]};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vsync_q <= 1'b0;
         x_cnt   <= '0;
         y_cnt   <= '0;
      end else begin
         vsync_q <= vsync;
         if (vsync) begin
            x_cnt <= '0;
            y_cnt <= '0;
         end else if (adv) begin
            if (x_cnt == COORD_W'(IMG_W - 1)) begin
               x_cnt <= '0;
               y_cnt <= (y_cnt == COORD_W'(IMG_H - 1)) ? '0 : y_cnt + COORD_W'(1);
            end else begin
               x_cnt <= x_cnt + COORD_W'(1);
            end
         end
      end
   end

   // A mask pixel coincident with eof seeds the next frame's moments.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         m00 <= '0;
         m10 <= '0;
         m01 <= '0;
      end else if (eof) begin
         m00 <= pix ? AREA_W'(1) : '0;
         m10 <= pix ? SUM_W'(x_cnt) : '0;
         m01 <= pix ? SUM_W'(y_cnt) : '0;
      end else if (pix) begin
         m00 <= m00 + AREA_W'(1);
         m10 <= m10 + SUM_W'(x_cnt);
         m01 <= m01 + SUM_W'(y_cnt);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sh_area  <= '0;
         sh_found <= 1'b0;
      end else if (snap) begin
         sh_area  <= m00;
         sh_found <= go;
      end
   end

   seq_divider #(.N_W(SUM_W), .D_W(AREA_W)) u_div_x (
      .clk      (clk),
      .rst_n    (rst),
      .start    (div_start),
      .dividend (m10),
      .divisor  (m00),
      .done     (dx_done),
      .quotient (qx)
   );

   seq_divider #(.N_W(SUM_W), .D_W(AREA_W)) u_div_y (
      .clk      (clk),
      .rst_n    (rst),
      .start    (div_start),
      .dividend (m01),
      .divisor  (m00),
      .done     (dy_done),
      .quotient (qy)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ST_IDLE;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      div_start = 1'b0;
      case (state)
         ST_IDLE: begin
            if (eof) begin
               state_nx  = go ? ST_DIV : ST_DONE;
               div_start = go;
            end
         end
         ST_DIV:  if (dx_done && dy_done) state_nx = ST_DONE;
         ST_DONE: state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid      <= 1'b0;
         frame_drop <= 1'b0;
         area       <= '0;
         found      <= 1'b0;
         x          <= '0;
         y          <= '0;
      end else begin
         valid      <= (state == ST_DONE);
         frame_drop <= eof && (state != ST_IDLE);
         if (state == ST_DONE) begin
            area  <= sh_area;
            found <= sh_found;
            x     <= sh_found ? qx[COORD_W-1:0] : '0;
            y     <= sh_found ? qy[COORD_W-1:0] : '0;
         end
      end
   end

`ifdef CENTROID_BBOX_EN
   logic [COORD_W-1:0] bx_lo, bx_hi, by_lo, by_hi;
   logic [COORD_W-1:0] sx_lo, sx_hi, sy_lo, sy_hi;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bx_lo <= '0;
         bx_hi <= '0;
         by_lo <= '0;
         by_hi <= '0;
      end else if (eof) begin
         bx_lo <= pix ? x_cnt : '1;
         bx_hi <= pix ? x_cnt : '0;
         by_lo <= pix ? y_cnt : '1;
         by_hi <= pix ? y_cnt : '0;
      end else if (pix) begin
         if (x_cnt < bx_lo) bx_lo <= x_cnt;
         if (x_cnt > bx_hi) bx_hi <= x_cnt;
         if (y_cnt < by_lo) by_lo <= y_cnt;
         if (y_cnt > by_hi) by_hi <= y_cnt;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sx_lo <= '0;
         sx_hi <= '0;
         sy_lo <= '0;
         sy_hi <= '0;
      end else if (snap) begin
         sx_lo <= bx_lo;
         sx_hi <= bx_hi;
         sy_lo <= by_lo;
         sy_hi <= by_hi;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         x_min <= '0;
         x_max <= '0;
         y_min <= '0;
         y_max <= '0;
      end else if (state == ST_DONE) begin
         x_min <= sh_found ? sx_lo : '0;
         x_max <= sh_found ? sx_hi : '0;
         y_min <= sh_found ? sy_lo : '0;
         y_max <= sh_found ? sy_hi : '0;
      end
   end
`else
   assign x_min = '0;
   assign x_max = '0;
   assign y_min = '0;
   assign y_max = '0;
`endif

endmodule
